// File: rtl/step_gen_dda.sv
// DDA step/direction generator: velocity integrates into a phase accumulator, half-wraps queue steps,
// a pulse FSM drives step/dir with setup/high/hold timing. Define STEP_GEN_DDA_ACCEL_EN for acceleration.
module step_gen_dda #(
  parameter int WIDTH        = 32,
  parameter int SETUP_CYCLES = 100,
  parameter int HIGH_CYCLES  = 300,
  parameter int HOLD_CYCLES  = 100,
  parameter int PEND_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [WIDTH-1:0]      velocity,
  input  logic                         load_velocity,
  input  logic signed [WIDTH-1:0]      acceleration,
  input  logic signed [WIDTH-1:0]      data_in,
  input  logic                         set_position,
  output logic signed [WIDTH-1:0]      position,
  output logic        [WIDTH-1:0]      acc,
  output logic signed [WIDTH-1:0]      cur_velocity,
  output logic signed [PEND_WIDTH-1:0] pending,
  output logic                         step,
  output logic                         dir,
  output logic                         busy,
  output logic                         overrun
);

  localparam int MAX_CYC_SH = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
  localparam int MAX_CYC    = (MAX_CYC_SH > HOLD_CYCLES) ? MAX_CYC_SH : HOLD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYC) + 1;
  localparam logic signed [PEND_WIDTH:0] PEND_ONE = (PEND_WIDTH+1)'(1);
  localparam logic signed [PEND_WIDTH:0] PEND_MAX = (PEND_WIDTH+1)'(2**(PEND_WIDTH-1) - 1);
  localparam logic signed [WIDTH-1:0]    POS_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_HOLD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               dir_nxt, start, pulse_done, first_pulse, discard;
  logic [WIDTH-1:0]   acc_sum;
  logic               step_event, ev_rev, ev_ovf;
  logic signed [PEND_WIDTH:0] pend_ext, pend_base, pend_ev, pend_nxt;

`ifdef STEP_GEN_DDA_ACCEL_EN
  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      sat_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sat_add = s[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset)              cur_velocity <= '0;
    else if (load_velocity) cur_velocity <= velocity;
    else if (enable)        cur_velocity <= sat_add(cur_velocity, acceleration);
  end
`else
  logic accel_unused;
  assign accel_unused = ^acceleration;

  always_ff @(posedge clk) begin
    if (reset)              cur_velocity <= '0;
    else if (load_velocity) cur_velocity <= velocity;
  end
`endif

  // Half-wrap of the accumulator MSB is a step event, signed by the velocity that was added.
  assign acc_sum    = acc + cur_velocity;
  assign step_event = enable && (acc_sum[WIDTH-1] != acc[WIDTH-1]);
  assign ev_rev     = cur_velocity[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset || set_position) acc <= '0;
    else if (enable)           acc <= acc_sum;
  end

  // Pulse start is applied first; the event is then dropped if it would leave +/-PEND_MAX.
  always_comb begin
    pend_ext  = {pending[PEND_WIDTH-1], pending};
    pend_base = pend_ext;
    if (start) pend_base = pending[PEND_WIDTH-1] ? pend_ext + PEND_ONE : pend_ext - PEND_ONE;
    pend_ev   = ev_rev ? pend_base - PEND_ONE : pend_base + PEND_ONE;
    ev_ovf    = step_event && ((pend_ev > PEND_MAX) || (pend_ev < -PEND_MAX));
    pend_nxt  = (step_event && !ev_ovf) ? pend_ev : pend_base;
  end

  always_ff @(posedge clk) begin
    if (reset || set_position) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= pend_nxt[PEND_WIDTH-1:0];
      if (ev_ovf) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_nxt    = dir;
    start      = 1'b0;
    pulse_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending != '0) begin
          start   = 1'b1;
          dir_nxt = pending[PEND_WIDTH-1];
          if ((dir_nxt != dir) || first_pulse) begin
            state_nxt = S_SETUP;
            cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
          end else begin
            state_nxt = S_HIGH;
            cnt_nxt   = CNT_W'(HIGH_CYCLES - 1);
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nxt = S_HIGH;
          cnt_nxt   = CNT_W'(HIGH_CYCLES - 1);
        end else cnt_nxt = cnt - CNT_W'(1);
      end
      S_HIGH: begin
        if (cnt == '0) begin
          state_nxt = S_HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
        end else cnt_nxt = cnt - CNT_W'(1);
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nxt  = S_IDLE;
          pulse_done = 1'b1;
        end else cnt_nxt = cnt - CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A preset during a pulse lets the pins finish but voids that pulse's position update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dir         <= 1'b0;
      step        <= 1'b0;
      busy        <= 1'b0;
      first_pulse <= 1'b1;
      discard     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
      step  <= (state_nxt == S_HIGH);
      busy  <= (state_nxt != S_IDLE);
      if (start) first_pulse <= 1'b0;
      if (set_position)    discard <= start || ((state != S_IDLE) && !pulse_done);
      else if (pulse_done) discard <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                       position <= '0;
    else if (set_position)           position <= data_in;
    else if (pulse_done && !discard) position <= dir ? position - POS_ONE : position + POS_ONE;
  end

endmodule

// File: doc/step_gen_dda.md
# step_gen_dda

Parametrised DDA step/direction generator, the successor to the single-channel 32-bit step generator in the motion core. It integrates a signed velocity into a phase accumulator. Each accumulator half-wrap becomes a step event. Events are buffered in a signed pending counter, so none are lost while a pulse is on the wire. Pulses are emitted with programmable direction-setup, high and hold times, and the block tracks absolute position. The block sits between the motion-command registers and the stepper-driver pins.

## Interface
- WIDTH, 32, width of accumulator, velocity, acceleration and position.
- SETUP_CYCLES, 100, dir-to-step setup time in clocks (>=1).
- HIGH_CYCLES, 300, step high time in clocks (>=1).
- HOLD_CYCLES, 100, step low hold after falling edge in clocks (>=1).
- PEND_WIDTH, 4, width of the signed pending-step counter.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  integrate velocity/acceleration when high.
- velocity  in  WIDTH  signed value loaded into cur_velocity.
- load_velocity  in  1  load velocity into cur_velocity.
- acceleration  in  WIDTH  signed per-cycle velocity increment.
- data_in  in  WIDTH  signed position preset.
- set_position  in  1  preset position, clear acc, pending and overrun.
- position  out  WIDTH  signed absolute step count.
- acc  out  WIDTH  phase accumulator.
- cur_velocity  out  WIDTH  signed active velocity.
- pending  out  PEND_WIDTH  signed queued steps: + is forward, - is reverse.
- step  out  1  step pin.
- dir  out  1  direction pin: 0 is forward (+1), 1 is reverse (-1).
- busy  out  1  pulse FSM not IDLE.
- overrun  out  1  sticky flag: a step event was dropped.

## Operation
- Reset: every output is 0; the FSM is in IDLE.
- Velocity: load_velocity sets cur_velocity to velocity. Otherwise, when enable is high, cur_velocity = sat(cur_velocity + acceleration). Saturation clamps to the signed WIDTH min/max. load_velocity has priority over acceleration and works regardless of enable.
- Accumulator: when enable is high, acc <= acc + cur_velocity. This uses the pre-update cur_velocity, and the addition wraps modulo 2^WIDTH. When enable is low, acc and cur_velocity hold.
- Step event: bit WIDTH-1 of acc changes on an update. The event sign is the sign of the cur_velocity value that was added.
- Pending counter:
  - A forward event adds +1 and a reverse event adds -1.
  - An FSM pulse start moves pending toward 0 by 1.
  - An event and a start on the same edge are both applied.
  - If an event would push pending past +max or -max (±(2^(PEND_WIDTH-1)-1)), the event is dropped and overrun is set.
- set_position has priority over all of the above:
  - position <= data_in; acc, pending and overrun are cleared.
  - cur_velocity is unaffected.
  - A pulse already in flight completes on the pins, but its position update is discarded.
- Pulse FSM states: IDLE, SETUP, HIGH, HOLD.
  - IDLE: if pending != 0, set dir from the sign of pending and consume one step. If the new dir differs from the current dir, or this is the first pulse since reset, go to SETUP. Otherwise go directly to HIGH.
  - SETUP lasts SETUP_CYCLES clocks with step=0.
  - HIGH lasts HIGH_CYCLES clocks with step=1.
  - HOLD lasts HOLD_CYCLES clocks with step=0.
  - On the edge leaving HOLD, position is updated ±1 per dir (unless discarded by set_position) and the FSM returns to IDLE.
- Pending keeps draining when enable is low.

## Timing
- An event at edge k makes pending nonzero after edge k.
- The FSM leaves IDLE at edge k+1, where dir updates and pending is consumed.
- step rises at edge k+1+SETUP_CYCLES, or at edge k+1 when SETUP is skipped. step is high for exactly HIGH_CYCLES clocks.
- Position updates HOLD_CYCLES clocks after step falls.
- Minimum same-direction pulse period is HIGH_CYCLES+HOLD_CYCLES+1 clocks.
- reset mid-pulse: step=0 and FSM=IDLE after the next edge.
- busy is registered: high from the IDLE exit edge to the HOLD exit edge.

## Configuration
- STEP_GEN_DDA_ACCEL_EN defined: the acceleration integration above is compiled in.
- Not defined: the acceleration port exists but is ignored. cur_velocity changes only through load_velocity or reset, and the saturating adder is removed.

## Test plan
Bench parameters for all scenarios: WIDTH=16, SETUP=2, HIGH=3, HOLD=2, PEND_WIDTH=4.

- Single forward step: load velocity 0x0100 with enable=1. After 128 updates the event fires; dir=0, step high for 3 clocks, position 0->1, pending returns to 0.
- Direction change: after scenario 1, load velocity 0xFF00 (-256). A reverse event enters SETUP (2 clocks with dir=1, step=0) before HIGH; position 1->0.
- Overrun: load velocity 0x4000, giving one event every 2 clocks against one pulse every 6 clocks. pending saturates at +7, overrun=1, and position keeps incrementing at 1 per 6 clocks.
- Acceleration (ACCEL_EN defined): load 0x7F00, then acceleration 0x0200 with enable=1. cur_velocity reads 0x7FFF from the 1st update and holds there. Without ACCEL_EN, cur_velocity stays 0x7F00.
- set_position mid-HIGH with data_in=1000: position=1000 after the edge and pending=0. step completes its 3 clocks, and position stays 1000 after HOLD.
- reset asserted during HIGH: step=0, busy=0, position=0 and pending=0 after the next edge.
